shift_arbiter: RTL and testbench

Round-robin arbiter and response stage that shares one combinational 32-bit shift unit among `NREQ` independent requesters. Each requester presents an operand, op code and count over a valid/ready handshake. The block grants one request per cycle, computes the result through the shared unit, and returns it through a single registered, tagged response channel. It sits between the issue logic and the writeback path.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_unit.sv | 45 ++++
 rtl/shift_arbiter.sv | 125 ++++++++++++
 tb/tb_shift_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared op-code encoding, widths and op-code legality helper
//               for the shared shift unit and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 5;

    typedef enum logic [OP_W-1:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SLA = 3'd2,
        SH_SRA = 3'd3,
        SH_ROL = 3'd4,
        SH_ROR = 3'd5
    } shift_op_t;

    // Codes 6 and 7 are reserved; everything up to SH_ROR is executable.
    function automatic logic shift_op_legal(input logic [OP_W-1:0] op);
        return (op <= SH_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_unit
// Description : Purely combinational 32-bit shifter/rotator. Illegal op
//               codes produce a zero result with err raised.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_unit
    import shift_pkg::*;
(
    input  logic [31:0] operand,
    input  logic [2:0]  op,
    input  logic [4:0]  cnt,
    output logic [31:0] result,
    output logic        err
);

    logic [5:0]  w_rev_cnt;
    logic [31:0] w_shl;
    logic [31:0] w_shr;
    logic [31:0] w_sra;

    // Complementary distance for rotates; a 32-bit shift yields zero, which
    // makes cnt=0 rotate back to the operand unchanged.
    assign w_rev_cnt = 6'd32 - {1'b0, cnt};
    assign w_shl     = operand << cnt;
    assign w_shr     = operand >> cnt;
    assign w_sra     = $signed(operand) >>> cnt;

    // Select the operation result and flag reserved op codes.
    always_comb begin
        result = '0;
        err    = !shift_op_legal(op);
        case (op)
            SH_SLL, SH_SLA: result = w_shl;
            SH_SRL:         result = w_shr;
            SH_SRA:         result = w_sra;
            SH_ROL:         result = w_shl | (operand >> w_rev_cnt);
            SH_ROR:         result = w_shr | (operand << w_rev_cnt);
            default:        result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter sharing one combinational shift unit
//               among NREQ requesters, with a single registered, tagged
//               response channel (valid/ready, no bubble on drain+grant).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_in,
    input  logic [NREQ*3-1:0] req_op,
    input  logic [NREQ*5-1:0] req_cnt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_err
);

    localparam logic [IDW:0]   C_NREQ_EXT = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] C_LAST_IDX = IDW'(NREQ - 1);

    logic [IDW-1:0] r_rr_ptr;
    logic           r_resp_valid;
    logic [31:0]    r_resp_data;
    logic [IDW-1:0] r_resp_id;
    logic           r_resp_err;

    logic           w_slot_free;
    logic           w_found;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_xfer;
    logic [31:0]    w_operand;
    logic [2:0]     w_op;
    logic [4:0]     w_cnt;
    logic [31:0]    w_result;
    logic           w_err;

    assign w_slot_free = !r_resp_valid || resp_ready;
    assign w_xfer      = w_found && w_slot_free && !reset;

    // First valid requester at or after the priority pointer, with wrap.
    always_comb begin : p_search
        logic [IDW:0] idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (idx >= C_NREQ_EXT) begin
                idx = idx - C_NREQ_EXT;
            end
            if (!w_found && req_valid[idx[IDW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = idx[IDW-1:0];
            end
        end
    end

    // One-hot grant; suppressed during reset and while the response stalls.
    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Route the granted requester's fields to the shared shift unit.
    always_comb begin
        w_operand = '0;
        w_op      = '0;
        w_cnt     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_operand = req_in[32*i +: 32];
                w_op      = req_op[3*i +: 3];
                w_cnt     = req_cnt[5*i +: 5];
            end
        end
    end

    shift_unit u_shift_unit (
        .operand (w_operand),
        .op      (w_op),
        .cnt     (w_cnt),
        .result  (w_result),
        .err     (w_err)
    );

    // Response register and priority pointer; a grant in the same cycle as a
    // drain reloads the register directly, so valid never drops between them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr     <= (w_gnt_idx == C_LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_result;
            r_resp_id    <= w_gnt_idx;
            r_resp_err   <= w_err;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Self-checking bench for shift_arbiter: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_in;
    logic [NREQ*3-1:0]   req_op;
    logic [NREQ*5-1:0]   req_cnt;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_data;
    logic [IDW-1:0]      resp_id;
    logic                resp_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_id    = 0;
    bit          m_err   = 1'b0;
    int          m_ptr   = 0;
    logic [NREQ-1:0] last_rdy;

    always #5 clk = ~clk;

    shift_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in     (req_in),
        .req_op     (req_op),
        .req_cnt    (req_cnt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    // One-bit-at-a-time reference of each operation.
    function automatic logic [31:0] ref_shift(logic [31:0] v, int op, int cnt);
        logic [31:0] r;
        r = v;
        if (op > 5) return 32'h0;
        for (int k = 0; k < cnt; k++) begin
            case (op)
                0, 2:    r = r * 2;
                1:       r = r / 2;
                3:       r = {r[31], r[31:1]};
                4:       r = {r[30:0], r[31]};
                default: r = {r[0], r[31:1]};
            endcase
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(int i, bit v, logic [31:0] d, int op, int cnt);
        req_valid[i]        = v;
        req_in[32*i +: 32]  = d;
        req_op[3*i +: 3]    = 3'(op);
        req_cnt[5*i +: 5]   = 5'(cnt);
    endtask

    // One clock: check the grant before the edge, advance the model, then
    // check the response register after the edge.
    task automatic tick();
        int          g;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0] nd;
        bit          ne;
        @(negedge clk);
        g = -1;
        if (!reset && (!m_valid || resp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        nd = '0;
        ne = 1'b0;
        if (g >= 0) begin
            nd = ref_shift(req_in[32*g +: 32], int'(req_op[3*g +: 3]), int'(req_cnt[5*g +: 5]));
            ne = (req_op[3*g +: 3] > 3'd5);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_data = nd; m_id = g; m_err = ne; m_ptr = (g + 1) % NREQ;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        chk("resp_valid", 32'(resp_valid), 32'(m_valid));
        chk("resp_data",  resp_data,        m_data);
        chk("resp_id",    32'(resp_id),     32'(m_id));
        chk("resp_err",   32'(resp_err),    32'(m_err));
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_in    = '0;
        req_op    = '0;
        req_cnt   = '0;
    endtask

    logic [31:0] cov_in  [4] = '{32'h80000001, 32'h80000001, 32'hF0000000, 32'h12345678};
    int          cov_op  [4] = '{4, 5, 1, 3};
    int          cov_cnt [4] = '{1, 1, 28, 0};
    logic [31:0] cov_exp [4] = '{32'h00000003, 32'hC0000000, 32'h0000000F, 32'h12345678};

    initial begin
        // Reset
        reset = 1'b1;
        resp_ready = 1'b0;
        clear_reqs();
        tick();
        tick();
        chk("reset_valid", 32'(resp_valid), 32'd0);
        chk("reset_data",  resp_data, 32'd0);

        // Single request: arithmetic right shift
        reset = 1'b0;
        resp_ready = 1'b1;
        set_req(0, 1'b1, 32'h80000000, 3, 4);
        tick();
        chk("sra_valid", 32'(resp_valid), 32'd1);
        chk("sra_data",  resp_data, 32'hF8000000);
        chk("sra_id",    32'(resp_id), 32'd0);
        chk("sra_err",   32'(resp_err), 32'd0);
        clear_reqs();

        // Op coverage on requester 2
        for (int k = 0; k < 4; k++) begin
            set_req(2, 1'b1, cov_in[k], cov_op[k], cov_cnt[k]);
            tick();
            chk("opcov_data", resp_data, cov_exp[k]);
            chk("opcov_id",   32'(resp_id), 32'd2);
        end
        for (int op = 0; op < 6; op++) begin
            set_req(2, 1'b1, 32'h12345678, op, 0);
            tick();
            chk("cnt0_data", resp_data, 32'h12345678);
        end
        clear_reqs();

        // Fairness: all valid after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'b1, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 31)));
            tick();
            chk("fair_id", 32'(resp_id), 32'(k % NREQ));
            chk("fair_onehot", 32'($countones(last_rdy)), 32'd1);
        end
        clear_reqs();

        // Backpressure with requesters 1 and 3
        set_req(1, 1'b1, 32'h0000F00F, 0, 4);
        set_req(3, 1'b1, 32'h0000000F, 5, 4);
        tick();
        chk("bp_first_id", 32'(resp_id), 32'd1);
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready", 32'(last_rdy), 32'd0);
            chk("bp_data",  resp_data, 32'h000F00F0);
            chk("bp_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        tick();
        chk("nobubble_valid", 32'(resp_valid), 32'd1);
        chk("nobubble_id",    32'(resp_id), 32'd3);
        chk("nobubble_data",  resp_data, 32'hF0000000);
        clear_reqs();

        // Illegal op, then a normal grant
        set_req(1, 1'b1, 32'hFFFFFFFF, 6, 0);
        tick();
        chk("illegal_data", resp_data, 32'd0);
        chk("illegal_err",  32'(resp_err), 32'd1);
        chk("illegal_id",   32'(resp_id), 32'd1);
        clear_reqs();
        set_req(2, 1'b1, 32'h00000001, 0, 1);
        tick();
        chk("after_illegal_data", resp_data, 32'd2);
        chk("after_illegal_err",  32'(resp_err), 32'd0);
        clear_reqs();

        // Reset while a response is stalled
        set_req(3, 1'b1, 32'hA5A5A5A5, 0, 0);
        tick();
        clear_reqs();
        resp_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("midreset_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'h1, 0, 0);
        tick();
        chk("postreset_id",  32'(resp_id), 32'd0);
        chk("postreset_rdy", 32'(last_rdy), 32'd1);
        clear_reqs();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 49) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), $urandom,
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
